// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } uart_state_e;

  localparam int UART_DATA_W = 8;

  // Width of uart_grant_t for a given requester count.
  function automatic int uart_grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating priority encoder: first valid requester strictly after rr_ptr, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = uart_grant_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GW-1:0]    rr_ptr,
  output logic [GW-1:0]    winner,
  output logic             any
);

  int idx;

  // Walk the rotation backwards so the nearest candidate is written last and wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    any    = |req_valid;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) winner = GW'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-locked round-robin scheduler feeding a single UART_TX serializer.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = UART_DATA_W,
  parameter int LOCK_TIMEOUT = 1023,
  localparam int GW          = uart_grant_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [GW-1:0]           grant_id,
  output logic                    active,
  output logic                    timeout_err
);

  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  uart_state_e       state_q;
  logic [GW-1:0]     rr_ptr_q;
  logic [GW-1:0]     grant_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              last_q;
  logic [CNT_W-1:0]  idle_cnt_q;
  logic [CNT_W-1:0]  idle_cnt_d;
  logic              timeout_q;

  logic [GW-1:0]     pick_winner;
  logic              pick_any;
  logic              owner_vld;
  logic              accept;
  logic              expired;

  uart_rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick_winner),
    .any       (pick_any)
  );

  assign owner_vld = req_valid[grant_q];
  assign accept    = (state_q == SEND) && owner_vld && !tx_busy;
  assign expired   = (LOCK_TIMEOUT != 0) && (state_q == SEND) && !owner_vld &&
                     (idle_cnt_q == CNT_LIM);
  assign idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;

  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= GW'(N_REQ - 1);
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_winner;
            idle_cnt_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            tx_data_q  <= req_data[int'(grant_q)*DATA_W +: DATA_W];
            tx_start_q <= 1'b1;
            last_q     <= req_last[grant_q];
            idle_cnt_q <= '0;
            state_q    <= WAIT_DONE;
          end else if (!owner_vld) begin
            idle_cnt_q <= idle_cnt_d;
            // Owner went quiet mid-packet: drop the lock so others are not starved.
            if (expired) begin
              timeout_q <= 1'b1;
              rr_ptr_q  <= grant_q;
              state_q   <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (last_q) begin
              rr_ptr_q <= grant_q;
              state_q  <= IDLE;
            end else begin
              idle_cnt_q <= '0;
              state_q    <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign active      = (state_q != IDLE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: arbitration table plus multi-cycle corner sequences.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic [1:0]    grant_id;
  logic          active;
  logic          timeout_err;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  uart_tx_sched #(.N_REQ(N), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && tx_start) start_cnt <= start_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] valid;
    logic [1:0] exp_g;
    logic [3:0] exp_rdy;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lane_byte(input int i);
    return 8'h10 + 8'(i) * 8'h11;
  endfunction

  task automatic set_lanes();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = lane_byte(i);
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1; req_valid = '0; req_last = '0; tx_busy = 1'b0; tx_done = 1'b0;
    set_lanes();
    #1;
    if (check) begin
      chk("rst_tx_start", 32'(tx_start), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      chk("rst_grant", 32'(grant_id), 32'h0);
      chk("rst_active", 32'(active), 32'h0);
      chk("rst_timeout", 32'(timeout_err), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
    end
    tick(); tick();
    reset = 1'b0;
  endtask

  // Serializer model: busy for n cycles after the start, then a done pulse.
  task automatic frame(input int n);
    tx_busy = 1'b1;
    repeat (n) tick();
    tx_busy = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_start === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  initial begin
    bit ok;
    int s0;

    tbl[0] = '{4'b0001, 2'd0, 4'b0001, 8'h10};
    tbl[1] = '{4'b0100, 2'd2, 4'b0100, 8'h32};
    tbl[2] = '{4'b1010, 2'd1, 4'b0010, 8'h21};
    tbl[3] = '{4'b1000, 2'd3, 4'b1000, 8'h43};
    tbl[4] = '{4'b1100, 2'd2, 4'b0100, 8'h32};
    tbl[5] = '{4'b1111, 2'd0, 4'b0001, 8'h10};

    // Single byte from requester 2, with reset-value checks.
    do_reset(1'b1);
    req_valid = 4'b0100; req_last = 4'b0100; req_data[2*DW +: DW] = 8'hA5;
    #1;
    chk("sb_idle_ready", 32'(req_ready), 32'h0);
    tick();
    chk("sb_grant", 32'(grant_id), 32'h2);
    chk("sb_active", 32'(active), 32'h1);
    chk("sb_ready", 32'(req_ready), 32'h4);
    chk("sb_nostart", 32'(tx_start), 32'h0);
    tick();
    chk("sb_start", 32'(tx_start), 32'h1);
    chk("sb_data", 32'(tx_data), 32'hA5);
    chk("sb_ready_wait", 32'(req_ready), 32'h0);
    req_valid = '0;
    frame(4);
    chk("sb_active_end", 32'(active), 32'h0);

    // Arbitration table from reset priority.
    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0);
      req_valid = tbl[v].valid; req_last = 4'b1111;
      tick();
      chk($sformatf("tbl%0d_grant", v), 32'(grant_id), 32'(tbl[v].exp_g));
      chk($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(tbl[v].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_start", v), 32'(tx_start), 32'h1);
      chk($sformatf("tbl%0d_data", v), 32'(tx_data), 32'(tbl[v].exp_data));
      req_valid = '0;
      frame(2);
      chk($sformatf("tbl%0d_idle", v), 32'(active), 32'h0);
    end

    // Fairness: everyone always has a one-byte packet.
    do_reset(1'b0);
    req_valid = 4'b1111; req_last = 4'b1111;
    s0 = start_cnt;
    for (int p = 0; p < 8; p++) begin
      wait_start(ok);
      chk($sformatf("fair%0d_seen", p), 32'(ok), 32'h1);
      chk($sformatf("fair%0d_grant", p), 32'(grant_id), 32'(p % 4));
      chk($sformatf("fair%0d_data", p), 32'(tx_data), 32'(lane_byte(p % 4)));
      frame(3);
      if (p == 3) chk("fair_round1_starts", 32'(start_cnt - s0), 32'h4);
      if (p == 7) chk("fair_round2_starts", 32'(start_cnt - s0), 32'h8);
    end

    // Packet lock: requester 1 keeps the grant for three bytes.
    do_reset(1'b0);
    req_valid = 4'b0010; req_last = 4'b0000; req_data[1*DW +: DW] = 8'h11;
    tick();
    s0 = start_cnt;
    chk("lock_grant1", 32'(grant_id), 32'h1);
    req_valid = 4'b0011; req_last = 4'b0001;
    #1;
    chk("lock_ready_b0", 32'(req_ready), 32'h2);
    tick();
    chk("lock_data0", 32'(tx_data), 32'h11);
    req_data[1*DW +: DW] = 8'h22;
    frame(3);
    chk("lock_ready_b1", 32'(req_ready), 32'h2);
    tick();
    chk("lock_start1", 32'(tx_start), 32'h1);
    chk("lock_data1", 32'(tx_data), 32'h22);
    req_data[1*DW +: DW] = 8'h33; req_last = 4'b0011;
    frame(3);
    chk("lock_ready_b2", 32'(req_ready), 32'h2);
    tick();
    chk("lock_start2", 32'(tx_start), 32'h1);
    chk("lock_data2", 32'(tx_data), 32'h33);
    req_valid = 4'b0001;
    frame(3);
    chk("lock_gap_idle", 32'(active), 32'h0);
    tick();
    chk("lock_grant0", 32'(grant_id), 32'h0);
    chk("lock_ready0", 32'(req_ready), 32'h1);
    chk("lock_starts", 32'(start_cnt - s0), 32'h3);

    // Timeout: requester 3 stalls mid-packet, requester 0 is waiting.
    do_reset(1'b0);
    req_valid = 4'b1000; req_last = 4'b0000;
    tick();
    chk("to_grant3", 32'(grant_id), 32'h3);
    req_valid = 4'b1001;
    tick();
    chk("to_start", 32'(tx_start), 32'h1);
    req_valid = 4'b0001;
    frame(3);
    chk("to_send_active", 32'(active), 32'h1);
    chk("to_send_ready", 32'(req_ready), 32'h0);
    for (int i = 1; i < LT; i++) begin
      tick();
      chk($sformatf("to_quiet%0d", i), 32'(timeout_err), 32'h0);
    end
    tick();
    chk("to_pulse", 32'(timeout_err), 32'h1);
    chk("to_idle", 32'(active), 32'h0);
    tick();
    chk("to_pulse_end", 32'(timeout_err), 32'h0);
    chk("to_next_grant", 32'(grant_id), 32'h0);
    chk("to_next_ready", 32'(req_ready), 32'h1);

    // Busy stall: no handshake until the serializer is free.
    do_reset(1'b0);
    tx_busy = 1'b1; req_valid = 4'b0001; req_last = 4'b0001;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("busy%0d_ready", i), 32'(req_ready), 32'h0);
      chk($sformatf("busy%0d_start", i), 32'(tx_start), 32'h0);
      tick();
    end
    tx_busy = 1'b0;
    #1;
    chk("busy_release_ready", 32'(req_ready), 32'h1);
    tick();
    chk("busy_release_start", 32'(tx_start), 32'h1);
    chk("busy_release_data", 32'(tx_data), 32'h10);

    // Reset during WAIT_DONE.
    do_reset(1'b0);
    req_valid = 4'b0100; req_last = 4'b0000;
    tick(); tick();
    chk("mid_start", 32'(tx_data), 32'h32);
    req_valid = '0; tx_busy = 1'b1;
    tick(); tick();
    chk("mid_active", 32'(active), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_active", 32'(active), 32'h0);
    chk("mid_rst_grant", 32'(grant_id), 32'h0);
    chk("mid_rst_data", 32'(tx_data), 32'h0);
    chk("mid_rst_start", 32'(tx_start), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_timeout", 32'(timeout_err), 32'h0);
    req_valid = 4'b0101; tx_busy = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_after_grant", 32'(grant_id), 32'h0);
    chk("mid_after_ready", 32'(req_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `UART_TX` serializer among `N_REQ` byte-stream requesters. Each requester offers bytes on a valid/ready handshake with a `last` marker. The grant is held for a whole packet, up to and including `last`, so that packets never interleave on the `Tx` line. The scheduler sits between the requester logic and the `UART_TX` core, and drives that core's start/data inputs.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `LOCK_TIMEOUT`, default 1023: cycles a locked requester may hold `req_valid` low mid-packet before the grant is revoked. A value of 0 disables the timeout.
- `clk` in, 1: single clock for all logic.
- `reset` in, 1: asynchronous, active-high reset.
- `req_valid` in, N_REQ: per-requester byte valid.
- `req_data` in, N_REQ*DATA_W: requester i's byte occupies bits [i*DATA_W +: DATA_W].
- `req_last` in, N_REQ: the offered byte ends the packet.
- `req_ready` out, N_REQ: byte accepted this cycle. This output is combinational and one-hot or zero.
- `tx_start` out, 1: one-cycle pulse to `UART_TX` that loads `tx_data`. Registered.
- `tx_data` out, DATA_W: byte for the serializer. Registered and held until the next start.
- `tx_busy` in, 1: the serializer is shifting a frame.
- `tx_done` in, 1: one-cycle pulse at the end of the stop bit.
- `grant_id` out, clog2(N_REQ): index of the current owner. Registered.
- `active` out, 1: a grant is held (the FSM is not in IDLE).
- `timeout_err` out, 1: one-cycle pulse when a lock is revoked.

## Operation
- FSM states: IDLE, SEND, WAIT_DONE.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit scanning upward from `rr_ptr+1`, wrapping modulo N_REQ.
  - Register the winner into `grant_id` and go to SEND.
- **SEND**
  - If `req_valid[grant_id]` is high and `tx_busy` is low, assert `req_ready[grant_id]` for that cycle.
  - On the same cycle, register `tx_data` from the requester's byte, set `tx_start` for the next cycle, latch `req_last` into `last_q`, and go to WAIT_DONE.
  - If `req_valid[grant_id]` is low, count idle cycles. When the count reaches LOCK_TIMEOUT (nonzero):
    - pulse `timeout_err`,
    - set `rr_ptr` to `grant_id`,
    - go to IDLE.
  - The idle counter clears on every accept and on entry to SEND.
- **WAIT_DONE**
  - Wait for `tx_done`.
  - If `last_q` is set: set `rr_ptr` to `grant_id` and go to IDLE.
  - Otherwise return to SEND, keeping the grant.
- `tx_done` is ignored outside WAIT_DONE.
- A `tx_done` arriving in the same cycle as `tx_start` is impossible by protocol and is not handled.
- Non-owners always see `req_ready`=0. Their `req_valid` may stay high indefinitely without side effects.
- A requester with `req_valid` high in IDLE wins within N_REQ packets (starvation bound).

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=N_REQ-1 (requester 0 has first priority),
  - `tx_start`=0, `tx_data`=0, `grant_id`=0,
  - `active`=0, `timeout_err`=0, `req_ready`=0,
  - idle counter 0, `last_q`=0.
- Reset asserted mid-frame returns everything to these values immediately. No partial byte is retried; `UART_TX` shares the reset.
- Latency:
  - `req_valid` first seen in IDLE on cycle 0,
  - `active`/`grant_id` valid on cycle 1,
  - `req_ready` on cycle 1 (when `tx_busy`=0),
  - `tx_start` on cycle 2.
- Back-to-back bytes of one packet: the next `req_ready` occurs 1 cycle after `tx_done`.
- After `last`: IDLE for 1 cycle, then the next grant. The minimum gap between packets at `tx_start` is 3 cycles after `tx_done`.
- Idle counter width is clog2(LOCK_TIMEOUT+1) and saturates at LOCK_TIMEOUT.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE/SEND/WAIT_DONE),
  - the default `DATA_W`,
  - the `uart_grant_t` width function (clog2).
- One sub-module: `uart_rr_pick`. It is a combinational rotate/priority encoder with inputs `req_valid` and `rr_ptr`, and outputs `winner` and `any`.
- All other logic lives in `uart_tx_sched`.

## Test plan
- **Single byte.** Reset, then requester 2 presents 0xA5 with `last`=1.
  - Required: `grant_id`=2 on cycle 1, `req_ready[2]` on cycle 1, `tx_start`=1 with `tx_data`=0xA5 on cycle 2.
  - After the model's `tx_done`, `active`=0.
- **Fairness.** All four requesters hold 1-byte packets continuously.
  - Required: grant order 0,1,2,3,0 and exactly four `tx_start` pulses per round.
- **Packet lock.** Requester 1 sends 0x11, 0x22, 0x33 (`last` on 0x33) while requester 0 is valid throughout.
  - Required: bytes 0x11, 0x22, 0x33 are contiguous on `tx_data`, and requester 0 is granted only after `tx_done` of 0x33.
- **Timeout.** With LOCK_TIMEOUT=8, requester 3 sends a non-last byte, then drops `req_valid`.
  - Required: `timeout_err` pulses 8 cycles after entry to SEND, followed by IDLE. A pending requester 0 is granted next.
- **Busy stall.** Hold `tx_busy`=1 for 20 cycles while in SEND.
  - Required: no `req_ready` and no `tx_start` until `tx_busy` falls, then acceptance on that cycle.
- **Reset mid-frame.** Assert `reset` during WAIT_DONE.
  - Required: all outputs return to reset values in the same cycle, and requester 0 wins first after release.
